decode_nw: RTL and testbench

Parametrised superscalar decode stage for the out-of-order RV32I core. It accepts a bundle of up to `WIDTH` fetched instructions per cycle and decodes each lane into a `decode_data` record (from `types_pkg`). Decoded records are buffered in a `DEPTH`-entry circular queue. Rename drains the queue in program order at up to `WIDTH` per cycle. It replaces the single-lane `decode` between fetch and rename.

---
 rtl/decode_nw.sv | 232 +++++++++++++++++++++++
 tb/tb_decode_nw.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_nw.sv
// decode_nw - superscalar decode stage with an in-order record queue.
//
// Up to WIDTH fetched RV32I instructions per cycle are decoded in parallel
// into decode_data records and pushed into a DEPTH-entry circular queue.
// Rename drains the queue in program order, up to WIDTH records per cycle.
//
// Parameters
//   WIDTH      lanes per bundle in and out (1..4)
//   DEPTH      queue entries, power of two, >= 2*WIDTH
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   instr      fetched instructions, lane i at [32*i +: 32]
//   pc_in      PC of lane 0 (lane i is pc_in + 4*i)
//   valid_in   contiguous lane mask starting at lane 0
//   ready_in   queue has room for a full bundle
//   valid_out  slot i holds a record
//   data_out   decoded records, slot 0 is the oldest
//   deq_cnt    records consumed by rename this cycle
//   flush      discard every buffered record
//   count      queue occupancy
//
// Build option
//   DECODE_BYPASS_EN  when defined, an empty queue forwards the incoming
//                     decoded lanes to the outputs in the same cycle.

package types_pkg;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  Opcode;
    logic [31:0] imm;
    logic [2:0]  ALUOp;
    logic [31:0] pc;
    logic        fu_alu;
    logic        fu_mem;
  } decode_data;

endpackage

module decode_nw
  import types_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [32*WIDTH-1:0]            instr,
  input  logic [31:0]                    pc_in,
  input  logic [WIDTH-1:0]               valid_in,
  output logic                           ready_in,
  output logic [WIDTH-1:0]               valid_out,
  output decode_data [WIDTH-1:0]         data_out,
  input  logic [$clog2(WIDTH+1)-1:0]     deq_cnt,
  input  logic                           flush,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Decode one instruction. Fields a format does not use stay zero, and an
  // unknown opcode yields a record carrying only pc and Opcode so rename can
  // recognise it by fu_alu = fu_mem = 0.
  function automatic decode_data decode_lane(input logic [31:0] ins,
                                             input logic [31:0] pc);
    decode_data d;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u = {ins[31:12], 12'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    d        = '0;
    d.pc     = pc;
    d.Opcode = ins[6:0];
    case (ins[6:0])
      OP_LOAD: begin
        d.rs1 = ins[19:15]; d.rd = ins[11:7]; d.imm = imm_i;
        d.ALUOp = 3'b000; d.fu_alu = 1'b1; d.fu_mem = 1'b1;
      end
      OP_STORE: begin
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.imm = imm_s;
        d.ALUOp = 3'b000; d.fu_alu = 1'b1; d.fu_mem = 1'b1;
      end
      OP_BRANCH: begin
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.imm = imm_b;
        d.ALUOp = 3'b001; d.fu_alu = 1'b1;
      end
      OP_REG: begin
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
        d.ALUOp = 3'b010; d.fu_alu = 1'b1;
      end
      OP_IMM: begin
        d.rs1 = ins[19:15]; d.rd = ins[11:7]; d.imm = imm_i;
        d.ALUOp = 3'b011; d.fu_alu = 1'b1;
      end
      OP_LUI: begin
        d.rd = ins[11:7]; d.imm = imm_u;
        d.ALUOp = 3'b100; d.fu_alu = 1'b1;
      end
      OP_AUIPC: begin
        d.rd = ins[11:7]; d.imm = imm_u;
        d.ALUOp = 3'b101; d.fu_alu = 1'b1;
      end
      OP_JALR: begin
        d.rs1 = ins[19:15]; d.rd = ins[11:7]; d.imm = imm_i;
        d.ALUOp = 3'b110; d.fu_alu = 1'b1;
      end
      OP_JAL: begin
        d.rd = ins[11:7]; d.imm = imm_j;
        d.ALUOp = 3'b111; d.fu_alu = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

  decode_data             mem [DEPTH];
  decode_data             dec [WIDTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       n_valid;
  logic [CNT_W-1:0]       deq_ext;
  logic [CNT_W-1:0]       deq_q;
  logic [CNT_W-1:0]       skip;
  logic [CNT_W-1:0]       enq_n;
  logic                   enq_acc;
  logic [PTR_W-1:0]       wr_idx [WIDTH];
  logic                   we     [WIDTH];
`ifdef DECODE_BYPASS_EN
  logic                   bypass_act;
`endif

  assign count = count_q;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = decode_lane(instr[32*i +: 32], pc_in + 32'(4*i));
    end
  end

  // valid_in is contiguous, so its popcount is also the number of lanes
  // from lane 0 that carry an instruction.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n_valid = n_valid + CNT_W'(valid_in[i]);
    end
  end

  // Room is judged on the registered occupancy only, so a bundle is never
  // accepted on the promise of a same-cycle dequeue.
  assign ready_in = (count_q <= CNT_W'(DEPTH - WIDTH));
  assign enq_acc  = ready_in && (valid_in != '0);
  assign deq_ext  = CNT_W'(deq_cnt);
  assign deq_q    = (deq_ext < count_q) ? deq_ext : count_q;

  // With bypass, rename may take the first lanes of a bundle straight from
  // the decoders while the queue is empty; only the rest are written.
`ifdef DECODE_BYPASS_EN
  assign bypass_act = (count_q == '0) && !flush && !reset;
  always_comb begin
    skip = '0;
    if (bypass_act && ready_in) begin
      skip = (deq_ext < n_valid) ? deq_ext : n_valid;
    end
  end
`else
  assign skip = '0;
`endif

  assign enq_n = enq_acc ? (n_valid - skip) : '0;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      wr_idx[i] = wr_ptr + PTR_W'(CNT_W'(i) - skip);
      we[i]     = enq_acc && valid_in[i] && (CNT_W'(i) >= skip);
    end
  end

  // Queue storage carries no reset: stale entries are never visible because
  // the outputs are masked by occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (we[i]) begin
        mem[wr_idx[i]] <= dec[i];
      end
    end
  end

  // Flush and reset share one path and win over any enqueue or dequeue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + deq_q[PTR_W-1:0];
      wr_ptr  <= wr_ptr + enq_n[PTR_W-1:0];
      count_q <= count_q + enq_n - deq_q;
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      valid_out[i] = (count_q > CNT_W'(i));
      data_out[i]  = valid_out[i] ? mem[rd_ptr + PTR_W'(i)] : '0;
`ifdef DECODE_BYPASS_EN
      if (bypass_act) begin
        valid_out[i] = valid_in[i] & ready_in;
        data_out[i]  = valid_out[i] ? dec[i] : '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_decode_nw.sv
// tb_decode_nw - directed bench for decode_nw (WIDTH=2, DEPTH=8).
// Expected records are pushed to a scoreboard queue when a bundle is
// accepted and are compared against the output slots each cycle.

module tb_decode_nw;
  import types_pkg::*;

  localparam int WIDTH = 2;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [63:0]      instr;
  logic [31:0]      pc_in;
  logic [1:0]       valid_in;
  logic             ready_in;
  logic [1:0]       valid_out;
  decode_data [1:0] data_out;
  logic [1:0]       deq_cnt;
  logic             flush;
  logic [3:0]       count;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  decode_data exp_q[$];
  decode_data lane_exp[2];
  int         k = 1;
  logic [31:0] pc_base = 32'h0000_1000;

  decode_nw #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instr(instr), .pc_in(pc_in),
    .valid_in(valid_in), .ready_in(ready_in), .valid_out(valid_out),
    .data_out(data_out), .deq_cnt(deq_cnt), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic decode_data mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd, input logic [6:0] op,
                                    input logic [31:0] imm, input logic [2:0] alu,
                                    input logic [31:0] pc, input logic falu,
                                    input logic fmem);
    decode_data d;
    d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.Opcode = op; d.imm = imm;
    d.ALUOp = alu; d.pc = pc; d.fu_alu = falu; d.fu_mem = fmem;
    return d;
  endfunction

  // ADDI x(n mod 32), x0, n : the immediate keeps records distinguishable.
  function automatic logic [31:0] addi_instr(input int n);
    logic [11:0] imm12;
    logic [4:0]  rd5;
    imm12 = 12'(n);
    rd5   = 5'(n);
    return {imm12, 5'd0, 3'b000, rd5, 7'b0010011};
  endfunction

  function automatic decode_data addi_exp(input int n, input logic [31:0] pc);
    return mk(5'd0, 5'd0, 5'(n), 7'h13, 32'(n), 3'b011, pc, 1'b1, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] expv);
    checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i0, input decode_data e0,
                               input logic [31:0] i1, input decode_data e1,
                               input logic [31:0] pc, input logic [1:0] v,
                               input logic [1:0] d);
    instr       = {i1, i0};
    lane_exp[0] = e0;
    lane_exp[1] = e1;
    pc_in       = pc;
    valid_in    = v;
    deq_cnt     = d;
    #1;
  endtask

  task automatic idle();
    applyStimulus(32'h0, '0, 32'h0, '0, 32'h0, 2'b00, 2'b00);
  endtask

  // Advance one clock, updating the scoreboard with what the edge does.
  task automatic step();
    int  nv, byp, n;
    bit  rdy;
    rdy = (DEPTH - exp_q.size()) >= WIDTH;
    nv  = valid_in[1] ? 2 : (valid_in[0] ? 1 : 0);
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      byp = 0;
`ifdef DECODE_BYPASS_EN
      if (exp_q.size() == 0 && rdy) byp = (int'(deq_cnt) < nv) ? int'(deq_cnt) : nv;
`endif
      n = (int'(deq_cnt) < exp_q.size()) ? int'(deq_cnt) : exp_q.size();
      repeat (n) void'(exp_q.pop_front());
      if (rdy) begin
        for (int i = byp; i < nv; i++) exp_q.push_back(lane_exp[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    decode_data es [2];
    logic [1:0] ev;
    int         sz;
    sz = exp_q.size();
    for (int i = 0; i < 2; i++) begin
      ev[i] = (i < sz);
      es[i] = (i < sz) ? exp_q[i] : '0;
    end
`ifdef DECODE_BYPASS_EN
    if (sz == 0 && !flush && !reset) begin
      for (int i = 0; i < 2; i++) begin
        ev[i] = valid_in[i];
        es[i] = valid_in[i] ? lane_exp[i] : '0;
      end
    end
`endif
    chk({tag, ".count"},    128'(count),       128'(sz));
    chk({tag, ".ready"},    128'(ready_in),    128'((DEPTH - sz) >= WIDTH));
    chk({tag, ".valid"},    128'(valid_out),   128'(ev));
    chk({tag, ".slot0"},    128'(data_out[0]), 128'(es[0]));
    chk({tag, ".slot1"},    128'(data_out[1]), 128'(es[1]));
  endtask

  // Push a bundle of ADDIs; numbering only advances if the bundle is taken.
  task automatic pushAddi(input logic [1:0] v, input logic [1:0] d);
    int  nv;
    bit  rdy;
    nv  = v[1] ? 2 : (v[0] ? 1 : 0);
    rdy = (DEPTH - exp_q.size()) >= WIDTH;
    applyStimulus(addi_instr(k), addi_exp(k, pc_base),
                  addi_instr(k + 1), addi_exp(k + 1, pc_base + 32'd4),
                  pc_base, v, d);
    step();
    if (rdy && !flush && !reset) begin
      k       = k + nv;
      pc_base = pc_base + 32'(4 * nv);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    idle();
    step();
    step();
    reset = 1'b0;
    idle();
    checkOutput("reset");

    applyStimulus(32'hFFF30293, mk(5'd6, 5'd0, 5'd5, 7'h13, 32'hFFFFFFFF, 3'b011, 32'h0, 1'b1, 1'b0),
                  32'hABCDE1B7, mk(5'd0, 5'd0, 5'd3, 7'h37, 32'hABCDE000, 3'b100, 32'h4, 1'b1, 1'b0),
                  32'h0, 2'b11, 2'b00);
    step();
    idle();
    checkOutput("addi_lui");
    applyStimulus(32'h0, '0, 32'h0, '0, 32'h0, 2'b00, 2'b10);
    step();
    idle();
    checkOutput("drain1");

    applyStimulus(32'hFF042503, mk(5'd8, 5'd0, 5'd10, 7'h03, 32'hFFFFFFF0, 3'b000, 32'h100, 1'b1, 1'b1),
                  32'h00542423, mk(5'd8, 5'd5, 5'd0, 7'h23, 32'h8, 3'b000, 32'h104, 1'b1, 1'b1),
                  32'h100, 2'b11, 2'b00);
    step();
    idle();
    checkOutput("lw_sw");
    applyStimulus(32'h0, '0, 32'h0, '0, 32'h0, 2'b00, 2'b10);
    step();
    idle();

    applyStimulus(32'h00209863, mk(5'd1, 5'd2, 5'd0, 7'h63, 32'h10, 3'b001, 32'h200, 1'b1, 1'b0),
                  32'h0, '0, 32'h200, 2'b01, 2'b00);
    step();
    applyStimulus(32'h00C000E7, mk(5'd0, 5'd0, 5'd1, 7'h67, 32'hC, 3'b110, 32'h204, 1'b1, 1'b0),
                  32'h0, '0, 32'h204, 2'b01, 2'b00);
    step();
    idle();
    checkOutput("bne_jalr");
    applyStimulus(32'h0, '0, 32'h0, '0, 32'h0, 2'b00, 2'b01);
    step();
    idle();
    checkOutput("deq_one");
    applyStimulus(32'h0, '0, 32'h0, '0, 32'h0, 2'b00, 2'b10);
    step();
    idle();
    checkOutput("deq_excess");
    applyStimulus(32'h0, '0, 32'h0, '0, 32'h0, 2'b00, 2'b10);
    step();
    idle();
    checkOutput("deq_empty");

    // Illegal opcode alongside an ADDI, with rename asking for two records.
    applyStimulus(32'h0000007F, mk(5'd0, 5'd0, 5'd0, 7'h7F, 32'h0, 3'b000, 32'h300, 1'b0, 1'b0),
                  addi_instr(99), addi_exp(99, 32'h304), 32'h300, 2'b11, 2'b10);
    checkOutput("illegal_same");
    step();
    idle();
    checkOutput("illegal_next");
    applyStimulus(32'h0, '0, 32'h0, '0, 32'h0, 2'b00, 2'b10);
    step();
    idle();
    checkOutput("illegal_drain");

    $display("[TB] fill and wrap");
    pushAddi(2'b01, 2'b00);
    idle();
    checkOutput("fill1");
    for (int r = 0; r < 3; r++) begin
      pushAddi(2'b11, 2'b00);
      idle();
      checkOutput("fill");
    end
    pushAddi(2'b11, 2'b00);
    idle();
    checkOutput("full_hold");
    pushAddi(2'b11, 2'b01);
    idle();
    checkOutput("full_deq");
    for (int r = 0; r < 20; r++) begin
      pushAddi(2'b11, 2'b10);
      idle();
      checkOutput("wrap");
    end
    for (int r = 0; r < 4; r++) begin
      applyStimulus(32'h0, '0, 32'h0, '0, 32'h0, 2'b00, 2'b10);
      step();
      idle();
      checkOutput("wrap_drain");
    end

    $display("[TB] flush and reset mid-fill");
    for (int r = 0; r < 3; r++) pushAddi(2'b11, 2'b00);
    idle();
    checkOutput("pre_flush");
    flush = 1'b1;
    pushAddi(2'b11, 2'b01);
    flush = 1'b0;
    idle();
    checkOutput("flush");
    for (int r = 0; r < 2; r++) pushAddi(2'b11, 2'b00);
    reset = 1'b1;
    pushAddi(2'b11, 2'b00);
    reset = 1'b0;
    idle();
    checkOutput("reset_mid");
    pushAddi(2'b11, 2'b00);
    idle();
    checkOutput("after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
